// File: rtl/control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, opcode-specific execute
// T3-T7, plus RESET wait, stop-driven PAUSE and HALT states.
module control_unit #(
  parameter int RESET_PC_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        con_ff,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        Cout,
  output logic        RAM_write_en,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        R_in,
  output logic        R_out,
  output logic        Baout,
  output logic        enableCon,
  output logic        enableInputPort,
  output logic        enableOutputPort,
  output logic        InPortout,
  output logic        Run,
  output logic [4:0]  operation
);

  typedef enum logic [3:0] {
    S_RESET, S_PAUSE,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_NEGNOT, C_IMM, C_MULDIV, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_e;

  localparam logic [1:0] WAIT_LAST = 2'(RESET_PC_WAIT);
  localparam logic [4:0] OP_ADD    = 5'd3;

  state_e      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  cls_e        cls;
  logic [4:0]  opcode;
  logic        ir_unused;
  logic        alu_class;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'd0:                                   cls = C_LD;
      5'd1:                                   cls = C_LDI;
      5'd2:                                   cls = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd8, 5'd9, 5'd10, 5'd11:               cls = C_ALU;
      5'd12, 5'd13, 5'd14:                    cls = C_IMM;
      5'd15, 5'd16:                           cls = C_MULDIV;
      5'd17, 5'd18:                           cls = C_NEGNOT;
      5'd19:                                  cls = C_BR;
      5'd20:                                  cls = C_JR;
      5'd22:                                  cls = C_IN;
      5'd23:                                  cls = C_OUT;
      5'd24:                                  cls = C_MFHI;
      5'd25:                                  cls = C_MFLO;
      5'd27:                                  cls = C_HALT;
      default:                                cls = C_NOP;
    endcase
  end

  assign alu_class = (cls == C_ALU) || (cls == C_IMM) ||
                     (cls == C_MULDIV) || (cls == C_NEGNOT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Every instruction's last step shares one exit: T0, or PAUSE when stop is high.
  always_comb begin
    state_e end_st;
    end_st  = stop ? S_PAUSE : S_T0;
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_RESET: begin
        if (wait_q == WAIT_LAST) state_d = end_st;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_PAUSE: if (!stop) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        case (cls)
          C_HALT:  state_d = S_HALT;
          C_NOP:   state_d = end_st;
          default: state_d = S_T3;
        endcase
      end
      S_T3: begin
        case (cls)
          C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: state_d = end_st;
          default:                           state_d = S_T4;
        endcase
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        case (cls)
          C_ALU, C_NEGNOT, C_IMM, C_LDI: state_d = end_st;
          default:                       state_d = S_T6;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV, C_BR: state_d = end_st;
          default:        state_d = S_T7;
        endcase
      end
      S_T7:    state_d = end_st;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    PCout            = 1'b0;
    ZHighout         = 1'b0;
    ZLowout          = 1'b0;
    MDRout           = 1'b0;
    MARin            = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    IRin             = 1'b0;
    Yin              = 1'b0;
    IncPC            = 1'b0;
    Read             = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    ZHIin            = 1'b0;
    ZLOin            = 1'b0;
    Cout             = 1'b0;
    RAM_write_en     = 1'b0;
    GRA              = 1'b0;
    GRB              = 1'b0;
    GRC              = 1'b0;
    R_in             = 1'b0;
    R_out            = 1'b0;
    Baout            = 1'b0;
    enableCon        = 1'b0;
    enableOutputPort = 1'b0;
    InPortout        = 1'b0;
    operation        = '0;
    enableInputPort  = (state_q != S_RESET) && (state_q != S_HALT);
    Run              = (state_q != S_RESET) && (state_q != S_HALT) &&
                       (state_q != S_PAUSE);

    case (state_q)
      S_T3, S_T4, S_T5, S_T6, S_T7: if (alu_class) operation = opcode;
      default: ;
    endcase
    if ((state_q == S_T4) && ((cls == C_LD) || (cls == C_LDI) || (cls == C_ST)))
      operation = OP_ADD;
    if ((state_q == S_T5) && (cls == C_BR))
      operation = OP_ADD;

    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
      end
      S_T1: begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU, C_NEGNOT, C_IMM: begin GRB = 1'b1; R_out = 1'b1; Yin = 1'b1; end
          C_LD, C_LDI, C_ST:      begin GRB = 1'b1; Baout = 1'b1; Yin = 1'b1; end
          C_MULDIV:               begin GRA = 1'b1; R_out = 1'b1; Yin = 1'b1; end
          C_BR:                   begin GRA = 1'b1; R_out = 1'b1; enableCon = 1'b1; end
          C_JR:                   begin GRA = 1'b1; R_out = 1'b1; PCin = 1'b1; end
          C_IN:                   begin InPortout = 1'b1; GRA = 1'b1; R_in = 1'b1; end
          C_OUT:                  begin GRA = 1'b1; R_out = 1'b1; enableOutputPort = 1'b1; end
          C_MFHI:                 begin HIout = 1'b1; GRA = 1'b1; R_in = 1'b1; end
          C_MFLO:                 begin LOout = 1'b1; GRA = 1'b1; R_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:                    begin GRC = 1'b1; R_out = 1'b1; ZLOin = 1'b1; end
          C_NEGNOT:                 begin GRB = 1'b1; R_out = 1'b1; ZLOin = 1'b1; end
          C_IMM, C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZLOin = 1'b1; end
          C_MULDIV: begin
            GRB = 1'b1; R_out = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1;
          end
          C_BR:                     begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_NEGNOT, C_IMM, C_LDI: begin ZLowout = 1'b1; GRA = 1'b1; R_in = 1'b1; end
          C_LD, C_ST:                    begin ZLowout = 1'b1; MARin = 1'b1; end
          C_MULDIV:                      begin ZLowout = 1'b1; LOin = 1'b1; end
          C_BR:                          begin Cout = 1'b1; ZLOin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin GRA = 1'b1; R_out = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          C_BR:     begin ZLowout = 1'b1; PCin = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; GRA = 1'b1; R_in = 1'b1; end
          C_ST:    RAM_write_en = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle strobe vectors compared against a
// step-table model built from the instruction timing rules.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, stop, con_ff;
  logic [31:0] IR;
  logic PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, HIin, LOin, HIout, LOout, ZHIin, ZLOin, Cout, RAM_write_en;
  logic GRA, GRB, GRC, R_in, R_out, Baout, enableCon, enableInputPort;
  logic enableOutputPort, InPortout, Run;
  logic [4:0] operation;

  int total = 0;
  int bad   = 0;

  localparam int B_PCOUT = 0,  B_ZHIGHOUT = 1,  B_ZLOWOUT = 2,  B_MDROUT = 3;
  localparam int B_MARIN = 4,  B_PCIN = 5,      B_MDRIN = 6,    B_IRIN = 7;
  localparam int B_YIN = 8,    B_INCPC = 9,     B_READ = 10,    B_HIIN = 11;
  localparam int B_LOIN = 12,  B_HIOUT = 13,    B_LOOUT = 14,   B_ZHIIN = 15;
  localparam int B_ZLOIN = 16, B_COUT = 17,     B_RAMW = 18,    B_GRA = 19;
  localparam int B_GRB = 20,   B_GRC = 21,      B_RIN = 22,     B_ROUT = 23;
  localparam int B_BAOUT = 24, B_ENCON = 25,    B_EIP = 26,     B_EOP = 27;
  localparam int B_INPORT = 28;
  localparam logic [34:0] PAUSE_VEC = 35'(1) << B_EIP;

  control_unit #(.RESET_PC_WAIT(1)) dut (
    .clk(clk), .clr(clr), .stop(stop), .IR(IR), .con_ff(con_ff),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .ZHIin(ZHIin), .ZLOin(ZLOin), .Cout(Cout),
    .RAM_write_en(RAM_write_en), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .R_in(R_in), .R_out(R_out), .Baout(Baout), .enableCon(enableCon),
    .enableInputPort(enableInputPort), .enableOutputPort(enableOutputPort),
    .InPortout(InPortout), .Run(Run), .operation(operation)
  );

  always #5 clk = ~clk;

  logic [34:0] obs;
  assign obs = {Run, operation, InPortout, enableOutputPort, enableInputPort,
                enableCon, Baout, R_out, R_in, GRC, GRB, GRA, RAM_write_en,
                Cout, ZLOin, ZHIin, LOout, HIout, LOin, HIin, Read, IncPC, Yin,
                IRin, MDRin, PCin, MARin, MDRout, ZLowout, ZHighout, PCout};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int instr_len(input int op);
    if (op == 0 || op == 2)                  return 8;
    if (op == 1)                             return 6;
    if (op >= 3 && op <= 14)                 return 6;
    if (op == 17 || op == 18)                return 6;
    if (op == 15 || op == 16 || op == 19)    return 7;
    if (op == 20 || (op >= 22 && op <= 25))  return 4;
    return 3;
  endfunction

  // Expected {Run, operation, strobes} for step k (0 = T0) of opcode op.
  function automatic logic [34:0] exp_vec(input int op, input int k, input bit con);
    logic [28:0] s;
    logic [4:0]  alu_op;
    s = '0;
    alu_op = '0;
    s[B_EIP] = 1'b1;
    if (k == 0) begin
      s[B_PCOUT] = 1'b1; s[B_MARIN] = 1'b1; s[B_INCPC] = 1'b1; s[B_ZLOIN] = 1'b1;
    end else if (k == 1) begin
      s[B_ZLOWOUT] = 1'b1; s[B_PCIN] = 1'b1; s[B_READ] = 1'b1; s[B_MDRIN] = 1'b1;
    end else if (k == 2) begin
      s[B_MDROUT] = 1'b1; s[B_IRIN] = 1'b1;
    end else begin
      if (op >= 3 && op <= 18) alu_op = op[4:0];
      if (op <= 2 && k == 4)   alu_op = 5'd3;
      if (op == 19 && k == 5)  alu_op = 5'd3;
      if ((op >= 3 && op <= 14) || op == 17 || op == 18) begin
        if (k == 3) begin s[B_GRB] = 1'b1; s[B_ROUT] = 1'b1; s[B_YIN] = 1'b1; end
        if (k == 4) begin
          if (op >= 12 && op <= 14) s[B_COUT] = 1'b1;
          else begin
            s[B_ROUT] = 1'b1;
            if (op <= 11) s[B_GRC] = 1'b1; else s[B_GRB] = 1'b1;
          end
          s[B_ZLOIN] = 1'b1;
        end
        if (k == 5) begin s[B_ZLOWOUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
      end else if (op <= 2) begin
        if (k == 3) begin s[B_GRB] = 1'b1; s[B_BAOUT] = 1'b1; s[B_YIN] = 1'b1; end
        if (k == 4) begin s[B_COUT] = 1'b1; s[B_ZLOIN] = 1'b1; end
        if (k == 5) begin
          s[B_ZLOWOUT] = 1'b1;
          if (op == 1) begin s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
          else s[B_MARIN] = 1'b1;
        end
        if (k == 6 && op == 0) begin s[B_READ] = 1'b1; s[B_MDRIN] = 1'b1; end
        if (k == 6 && op == 2) begin s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_MDRIN] = 1'b1; end
        if (k == 7 && op == 0) begin s[B_MDROUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
        if (k == 7 && op == 2) s[B_RAMW] = 1'b1;
      end else if (op == 15 || op == 16) begin
        if (k == 3) begin s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_YIN] = 1'b1; end
        if (k == 4) begin
          s[B_GRB] = 1'b1; s[B_ROUT] = 1'b1; s[B_ZHIIN] = 1'b1; s[B_ZLOIN] = 1'b1;
        end
        if (k == 5) begin s[B_ZLOWOUT] = 1'b1; s[B_LOIN] = 1'b1; end
        if (k == 6) begin s[B_ZHIGHOUT] = 1'b1; s[B_HIIN] = 1'b1; end
      end else if (op == 19) begin
        if (k == 3) begin s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_ENCON] = 1'b1; end
        if (k == 4) begin s[B_PCOUT] = 1'b1; s[B_YIN] = 1'b1; end
        if (k == 5) begin s[B_COUT] = 1'b1; s[B_ZLOIN] = 1'b1; end
        if (k == 6) begin s[B_ZLOWOUT] = 1'b1; s[B_PCIN] = con; end
      end else if (k == 3) begin
        case (op)
          20: begin s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_PCIN] = 1'b1; end
          22: begin s[B_INPORT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
          23: begin s[B_GRA] = 1'b1; s[B_ROUT] = 1'b1; s[B_EOP] = 1'b1; end
          24: begin s[B_HIOUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
          25: begin s[B_LOOUT] = 1'b1; s[B_GRA] = 1'b1; s[B_RIN] = 1'b1; end
          default: ;
        endcase
      end
    end
    return {1'b1, alu_op, s};
  endfunction

  // Entered with the DUT sampled in T0; leaves it sampled in the next T0.
  task automatic drive_instr(input int op, input bit con, output int ramw);
    logic [34:0] exp;
    logic [4:0]  opc;
    opc = op[4:0];
    IR = {opc, 27'($urandom)};
    con_ff = con;
    ramw = 0;
    for (int k = 0; k < instr_len(op); k++) begin
      if (k > 0) tick;
      exp = exp_vec(op, k, con);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL instr op=%0d step=T%0d con=%0b: got %h want %h", op, k, con, obs, exp);
      end
      if (RAM_write_en === 1'b1) ramw++;
    end
    tick;
  endtask

  task automatic test_reset;
    clr = 1'b0; stop = 1'b0; con_ff = 1'b0; IR = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_hold cyc=%0d: got %h want 0", i, obs); end
    end
    clr = 1'b1;
    tick;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_wait: got %h want 0", obs); end
    tick;
    total++;
    if (obs !== exp_vec(26, 0, 1'b0)) begin
      bad++; $display("FAIL reset_to_t0: got %h want %h", obs, exp_vec(26, 0, 1'b0));
    end
  endtask

  task automatic test_add;
    int rw;
    drive_instr(3, 1'b0, rw);
    total++;
    if (obs !== exp_vec(3, 0, 1'b0)) begin
      bad++; $display("FAIL add_length: got %h want T0 %h", obs, exp_vec(3, 0, 1'b0));
    end
  endtask

  task automatic test_store;
    int rw;
    drive_instr(2, 1'b0, rw);
    total++;
    if (rw !== 1) begin bad++; $display("FAIL st_write_count: got %0d want 1", rw); end
  endtask

  task automatic test_branch;
    int rw;
    drive_instr(19, 1'b0, rw);
    drive_instr(19, 1'b1, rw);
    total++;
    if (obs !== exp_vec(19, 0, 1'b0)) begin
      bad++; $display("FAIL br_length: got %h want %h", obs, exp_vec(19, 0, 1'b0));
    end
  endtask

  task automatic test_random;
    int rw, op;
    bit c;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      c = 1'($urandom_range(0, 1));
      drive_instr(op, c, rw);
    end
  endtask

  task automatic test_stop;
    logic [34:0] exp;
    IR = {5'd3, 27'($urandom)};
    con_ff = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      exp = exp_vec(3, k, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL stop_add step=T%0d: got %h want %h", k, obs, exp);
      end
      if (k == 4) stop = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (obs !== PAUSE_VEC) begin
        bad++; $display("FAIL stop_pause cyc=%0d: got %h want %h", i, obs, PAUSE_VEC);
      end
    end
    stop = 1'b0;
    tick;
    total++;
    if (obs !== exp_vec(26, 0, 1'b0)) begin
      bad++; $display("FAIL stop_resume: got %h want %h", obs, exp_vec(26, 0, 1'b0));
    end
  endtask

  task automatic test_async_reset;
    logic [34:0] exp;
    IR = {5'd0, 27'($urandom)};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick;
      exp = exp_vec(0, k, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL areset_ld step=T%0d: got %h want %h", k, obs, exp);
      end
    end
    clr = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL areset_immediate: got %h want 0", obs); end
    tick;
    stop = 1'b1;
    clr = 1'b1;
    tick;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL areset_wait: got %h want 0", obs); end
    tick;
    total++;
    if (obs !== PAUSE_VEC) begin
      bad++; $display("FAIL areset_to_pause: got %h want %h", obs, PAUSE_VEC);
    end
    stop = 1'b0;
    tick;
    total++;
    if (obs !== exp_vec(26, 0, 1'b0)) begin
      bad++; $display("FAIL areset_resume: got %h want %h", obs, exp_vec(26, 0, 1'b0));
    end
  endtask

  task automatic test_halt;
    logic [34:0] exp;
    IR = {5'd27, 27'($urandom)};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick;
      exp = exp_vec(27, k, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL halt_fetch step=T%0d: got %h want %h", k, obs, exp);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      total++;
      if (obs !== '0) begin bad++; $display("FAIL halt_hold cyc=%0d: got %h want 0", i, obs); end
    end
    clr = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL halt_clr: got %h want 0", obs); end
    tick;
    clr = 1'b1;
    tick;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL halt_reset_wait: got %h want 0", obs); end
    tick;
    total++;
    if (obs !== exp_vec(26, 0, 1'b0)) begin
      bad++; $display("FAIL halt_restart: got %h want %h", obs, exp_vec(26, 0, 1'b0));
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_store;
    test_branch;
    test_random;
    test_stop;
    test_async_reset;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
